// File: rtl/priority_scan_encoder_pkg.sv
// Shared types and helpers for the priority scan encoder.
package priority_scan_pkg;

  // Widest request vector the encoder supports.
  localparam int MAX_WIDTH = 256;
  localparam int MAX_CNT_W = $clog2(MAX_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Population count of the lowest 'width' bits of a zero-extended vector.
  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] vec,
                                                    input int                  width);
    logic [MAX_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) cnt += MAX_CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/priority_scan_encoder_if.sv
// Producer/consumer bus of the priority scan encoder.
interface priority_scan_if #(
  parameter int WIDTH = 8
);
  localparam int POS_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] pos;
  logic             out_last;
  logic [CNT_W-1:0] hit_count;
  logic             none;

  // Environment side: produces vectors and consumes beats.
  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, pos, out_last, hit_count, none
  );

  // Encoder side.
  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, pos, out_last, hit_count, none
  );
endinterface

// File: rtl/priority_scan_encoder_pick.sv
// Combinational picker: highest-priority set bit of a vector.
module priority_pick
  import priority_scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  localparam int POS_W    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [POS_W-1:0] o_idx,
  output logic [WIDTH-1:0] o_onehot,
  output logic             o_found,
  output logic             o_single
);

  // Scan so that the highest-priority set bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_idx    = '0;
    o_onehot = '0;
    o_found  = 1'b0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_vec[i]) begin
          o_idx       = POS_W'(i);
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_found     = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_vec[i]) begin
          o_idx       = POS_W'(i);
          o_onehot    = '0;
          o_onehot[i] = 1'b1;
          o_found     = 1'b1;
        end
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign o_single = o_found && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: emits the index of every set bit of an
// accepted vector, one per beat, in priority order.
module priority_scan_encoder
  import priority_scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0,
  localparam int POS_W    = $clog2(WIDTH),
  localparam int CNT_W    = $clog2(WIDTH + 1)
) (
  input logic            clk,
  input logic            areset,
  priority_scan_if.slave bus
);

  scan_state_t      r_state;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_hit_count;
  logic             r_none;

  logic [POS_W-1:0] w_idx;
  logic [WIDTH-1:0] w_onehot;
  logic             w_found;
  logic             w_single;
  logic             w_out_valid;
  logic             w_out_fire;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_in_zero;

  // Outputs are decoded from the mask register only, never from bus.in.
  priority_pick #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_pick (
    .i_vec    (r_mask),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_found  (w_found),
    .o_single (w_single)
  );

  assign w_out_valid = (r_state == SCAN);
  assign w_out_fire  = w_out_valid && bus.out_ready;
  // Accept a new vector while idle or during the final beat (zero-bubble reload).
  assign w_in_ready  = (r_state == IDLE) || (w_out_fire && w_single);
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_in_zero   = (bus.in == '0);

  // Scan FSM: load on accept, clear the emitted bit on each beat transfer.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= IDLE;
      r_mask      <= '0;
      r_hit_count <= '0;
      r_none      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_none <= w_in_fire && w_in_zero;
      unique case (r_state)
        IDLE: begin
          if (w_in_fire && !w_in_zero) begin
            r_mask      <= bus.in;
            r_hit_count <= CNT_W'(popcount(MAX_WIDTH'(bus.in), WIDTH));
            r_state     <= SCAN;
          end
        end
        SCAN: begin
          if (w_out_fire) begin
            if (w_in_fire && !w_in_zero) begin
              r_mask      <= bus.in;
              r_hit_count <= CNT_W'(popcount(MAX_WIDTH'(bus.in), WIDTH));
            end else begin
              r_mask <= r_mask & ~w_onehot;
              if (w_single) r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.pos       = w_idx;
  assign bus.out_last  = w_single;
  assign bus.hit_count = r_hit_count;
  assign bus.none      = r_none;

  // w_found is implied by out_valid (the mask is never zero while scanning).
  logic w_unused;
  assign w_unused = w_found;

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench for priority_scan_encoder: LSB-first 8-bit, MSB-first
// 8-bit and LSB-first 16-bit instances on a shared clock and reset.
module tb_priority_scan_encoder;

  logic clk;
  logic areset;
  int   n_checks;
  int   n_pass;

  priority_scan_if #(.WIDTH(8))  if_a ();
  priority_scan_if #(.WIDTH(8))  if_b ();
  priority_scan_if #(.WIDTH(16)) if_c ();

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(0)) u_dut_a (
    .clk    (clk),
    .areset (areset),
    .bus    (if_a.slave)
  );

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1)) u_dut_b (
    .clk    (clk),
    .areset (areset),
    .bus    (if_b.slave)
  );

  priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(0)) u_dut_c (
    .clk    (clk),
    .areset (areset),
    .bus    (if_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    areset   = 1'b1;
    if_a.in_valid = 1'b0; if_a.in = '0; if_a.out_ready = 1'b1;
    if_b.in_valid = 1'b0; if_b.in = '0; if_b.out_ready = 1'b1;
    if_c.in_valid = 1'b0; if_c.in = '0; if_c.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_none",      32'(if_a.none),      32'd0);
    check("rst_hit_count", 32'(if_a.hit_count), 32'd0);
    check("rst_in_ready",  32'(if_a.in_ready),  32'd1);
    tick();
    tick();
    areset = 1'b0;

    // 1: 8'b1010_0100 lowest-first -> 2, 5, 7(last).
    if_a.in_valid = 1'b1; if_a.in = 8'hA4;
    #1 check("t1_accept_ready", 32'(if_a.in_ready), 32'd1);
    tick();
    if_a.in_valid = 1'b0;
    #1;
    check("t1_b0_valid", 32'(if_a.out_valid), 32'd1);
    check("t1_b0_pos",   32'(if_a.pos),       32'd2);
    check("t1_b0_last",  32'(if_a.out_last),  32'd0);
    check("t1_hits",     32'(if_a.hit_count), 32'd3);
    tick(); #1;
    check("t1_b1_pos",   32'(if_a.pos),       32'd5);
    check("t1_b1_last",  32'(if_a.out_last),  32'd0);
    check("t1_b1_ready", 32'(if_a.in_ready),  32'd0);
    tick(); #1;
    check("t1_b2_pos",   32'(if_a.pos),       32'd7);
    check("t1_b2_last",  32'(if_a.out_last),  32'd1);
    check("t1_b2_ready", 32'(if_a.in_ready),  32'd1);
    tick(); #1;
    check("t1_idle_valid", 32'(if_a.out_valid), 32'd0);

    // 2: zero vector -> one-cycle none pulse, hit_count unchanged.
    if_a.in_valid = 1'b1; if_a.in = 8'h00;
    tick();
    if_a.in_valid = 1'b0;
    #1;
    check("t2_none",      32'(if_a.none),      32'd1);
    check("t2_valid",     32'(if_a.out_valid), 32'd0);
    check("t2_ready",     32'(if_a.in_ready),  32'd1);
    check("t2_hits",      32'(if_a.hit_count), 32'd3);
    tick(); #1;
    check("t2_none_drop", 32'(if_a.none),      32'd0);

    // 3: 8'h81 with a 3-cycle stall; an input offered during the stall is ignored.
    if_a.in_valid = 1'b1; if_a.in = 8'h81; if_a.out_ready = 1'b0;
    tick();
    if_a.in = 8'h18;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3_hold_pos",   32'(if_a.pos),      32'd0);
      check("t3_hold_last",  32'(if_a.out_last), 32'd0);
      check("t3_hold_ready", 32'(if_a.in_ready), 32'd0);
      tick();
    end
    if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
    #1;
    check("t3_b0_pos",  32'(if_a.pos),       32'd0);
    check("t3_hits",    32'(if_a.hit_count), 32'd2);
    tick(); #1;
    check("t3_b1_pos",  32'(if_a.pos),       32'd7);
    check("t3_b1_last", 32'(if_a.out_last),  32'd1);
    tick(); #1;
    check("t3_idle",    32'(if_a.out_valid), 32'd0);

    // 4: back-to-back 8'h01 then 8'h80 on the last beat, no bubble.
    if_a.in_valid = 1'b1; if_a.in = 8'h01;
    tick();
    if_a.in = 8'h80;
    #1;
    check("t4_b0_pos",   32'(if_a.pos),      32'd0);
    check("t4_b0_last",  32'(if_a.out_last), 32'd1);
    check("t4_b0_ready", 32'(if_a.in_ready), 32'd1);
    tick();
    if_a.in_valid = 1'b0;
    #1;
    check("t4_b1_valid", 32'(if_a.out_valid), 32'd1);
    check("t4_b1_pos",   32'(if_a.pos),       32'd7);
    check("t4_b1_last",  32'(if_a.out_last),  32'd1);
    check("t4_hits",     32'(if_a.hit_count), 32'd1);
    tick(); #1;
    check("t4_idle",     32'(if_a.out_valid), 32'd0);

    // 5: MSB-first 8'h24 -> 5, 2(last); 16-bit 16'h8000 -> 15(last).
    if_b.in_valid = 1'b1; if_b.in = 8'h24;
    if_c.in_valid = 1'b1; if_c.in = 16'h8000;
    tick();
    if_b.in_valid = 1'b0;
    if_c.in_valid = 1'b0;
    #1;
    check("t5_msb_b0_pos",  32'(if_b.pos),       32'd5);
    check("t5_msb_b0_last", 32'(if_b.out_last),  32'd0);
    check("t5_msb_hits",    32'(if_b.hit_count), 32'd2);
    check("t5_w16_pos",     32'(if_c.pos),       32'd15);
    check("t5_w16_last",    32'(if_c.out_last),  32'd1);
    check("t5_w16_hits",    32'(if_c.hit_count), 32'd1);
    tick(); #1;
    check("t5_msb_b1_pos",  32'(if_b.pos),       32'd2);
    check("t5_msb_b1_last", 32'(if_b.out_last),  32'd1);
    check("t5_w16_idle",    32'(if_c.out_valid), 32'd0);

    // 6: 8'hFF interrupted by reset after 3 beats, then 8'h10.
    if_a.in_valid = 1'b1; if_a.in = 8'hFF;
    tick();
    if_a.in_valid = 1'b0;
    #1 check("t6_b0_pos", 32'(if_a.pos), 32'd0);
    tick(); tick(); tick();
    #1 check("t6_b3_pos", 32'(if_a.pos), 32'd3);
    areset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(if_a.out_valid), 32'd0);
    check("t6_rst_hits",  32'(if_a.hit_count), 32'd0);
    tick();
    areset = 1'b0;
    #1;
    check("t6_rel_ready", 32'(if_a.in_ready),  32'd1);
    check("t6_rel_valid", 32'(if_a.out_valid), 32'd0);
    if_a.in_valid = 1'b1; if_a.in = 8'h10;
    tick();
    if_a.in_valid = 1'b0;
    #1;
    check("t6_new_pos",  32'(if_a.pos),       32'd4);
    check("t6_new_last", 32'(if_a.out_last),  32'd1);
    check("t6_new_hits", 32'(if_a.hit_count), 32'd1);
    tick(); #1;
    check("t6_idle",     32'(if_a.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
